// File: rtl/decode_imm_ctrl_if.sv
// Fetch/execute-side bundle of the decode immediate controller.
// Member names match the controller's port list; slave is the controller side.
interface decode_imm_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             i_in_valid;
    logic             o_in_ready;
    logic [31:0]      i_instr;
    logic             i_flush;
    logic [31:0]      o_gen_instr;
    logic [2:0]       o_gen_sel;
    logic [31:0]      i_gen_imm;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [31:0]      o_instr;
    logic [31:0]      o_imm;
    logic [2:0]       o_imm_sel;
    logic             o_illegal;
    logic [CNT_W-1:0] o_dec_count;

    modport slave (
        input  i_in_valid, i_instr, i_flush, i_gen_imm, i_out_ready,
        output o_in_ready, o_gen_instr, o_gen_sel, o_out_valid,
        output o_instr, o_imm, o_imm_sel, o_illegal, o_dec_count
    );

    modport master (
        output i_in_valid, i_instr, i_flush, i_gen_imm, i_out_ready,
        input  o_in_ready, o_gen_instr, o_gen_sel, o_out_valid,
        input  o_instr, o_imm, o_imm_sel, o_illegal, o_dec_count
    );
endinterface

// File: rtl/decode_imm_ctrl.sv
// Decode-stage immediate-select controller with a two-entry skid buffer
// between fetch and execute; in_ready/out_valid come straight from state.
module decode_imm_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    decode_imm_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic        ill;
    } entry_t;

    state_t           r_state;
    state_t           w_state_n;
    entry_t           r_main;
    entry_t           r_skid;
    entry_t           w_new;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       w_op;
    logic [2:0]       w_f3;
    logic [2:0]       w_sel;
    logic             w_ill;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_ld_main;
    logic             w_ld_skid;
    logic             w_shift;

    assign w_op = bus.i_instr[6:0];
    assign w_f3 = bus.i_instr[14:12];

    // All listed opcodes end in 2'b11, so the arms are mutually exclusive.
    always_comb begin
        w_sel = 3'd7;
        w_ill = 1'b0;
        unique case (1'b1)
            (w_op[1:0] != 2'b11): w_ill = 1'b1;
            (w_op == 7'b0000011 || w_op == 7'b1100111 ||
             w_op == 7'b1110011): w_sel = 3'd0;
            (w_op == 7'b0010011):
                w_sel = (w_f3 == 3'b001 || w_f3 == 3'b101) ? 3'd1 : 3'd0;
            (w_op == 7'b0100011): w_sel = 3'd2;
            (w_op == 7'b1100011): w_sel = 3'd3;
            (w_op == 7'b0110111 || w_op == 7'b0010111): w_sel = 3'd4;
            (w_op == 7'b1101111): w_sel = 3'd5;
            (w_op == 7'b0110011): w_sel = 3'd7;
            default: w_ill = 1'b1;
        endcase
    end

    assign bus.o_gen_instr = bus.i_instr;
    assign bus.o_gen_sel   = w_sel;

    assign w_new      = '{instr: bus.i_instr, imm: bus.i_gen_imm,
                          sel: w_sel, ill: w_ill};
    assign w_in_fire  = bus.i_in_valid & bus.o_in_ready;
    assign w_out_fire = bus.o_out_valid & bus.i_out_ready;

    always_comb begin
        w_state_n = r_state;
        w_ld_main = 1'b0;
        w_ld_skid = 1'b0;
        w_shift   = 1'b0;
        if (bus.i_flush) begin
            w_state_n = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_n = S_ONE;
                        w_ld_main = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_ld_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_n = S_TWO;
                        w_ld_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_n = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_out_fire) begin
                        w_state_n = S_ONE;
                        w_shift   = 1'b1;
                    end
                end
                default: w_state_n = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_ld_main) begin
                r_main <= w_new;
            end else if (w_shift) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_new;
            end
            if (w_out_fire) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.o_in_ready  = (r_state != S_TWO);
    assign bus.o_out_valid = (r_state != S_EMPTY);
    assign bus.o_instr     = r_main.instr;
    assign bus.o_imm       = r_main.imm;
    assign bus.o_imm_sel   = r_main.sel;
    assign bus.o_illegal   = r_main.ill;
    assign bus.o_dec_count = r_cnt;
endmodule

// File: tb/tb_decode_imm_ctrl.sv
// Bench for decode_imm_ctrl: queue model checked every cycle plus
// directed vectors with literal expectations.
module tb_decode_imm_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_imm_ctrl_if #(.CNT_W(16)) bus ();
    decode_imm_ctrl_if #(.CNT_W(4))  bus4 ();

    decode_imm_ctrl #(.CNT_W(16)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    decode_imm_ctrl #(.CNT_W(4)) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus4)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic        ill;
    } ent_t;

    ent_t        q[$];
    logic [15:0] mcnt = '0;

    function automatic logic [3:0] ref_dec(input logic [31:0] i);
        // returns {illegal, sel}
        if (i[1:0] != 2'b11) return 4'b1111;
        case (i[6:2])
            5'b00000, 5'b11001, 5'b11100: return 4'd0;
            5'b00100: return (i[13:12] == 2'b01) ? 4'd1 : 4'd0;
            5'b01000: return 4'd2;
            5'b11000: return 4'd3;
            5'b01101, 5'b00101: return 4'd4;
            5'b11011: return 4'd5;
            5'b01100: return 4'd7;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i,
                                            input logic [2:0] s);
        int v;
        case (s)
            3'd0: v = $signed(i) >>> 20;
            3'd1: v = int'(i[24:20]);
            3'd2: v = ($signed(i) >>> 25) * 32 + int'(i[11:7]);
            3'd3: v = ($signed(i) >>> 31) * 4096 + int'(i[7]) * 2048
                      + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            3'd4: v = int'(i & 32'hFFFF_F000);
            3'd5: v = ($signed(i) >>> 31) * 1048576 + int'(i[19:12]) * 4096
                      + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic ent_t mk(input logic [31:0] i);
        ent_t e;
        logic [3:0] d;
        d = ref_dec(i);
        e.instr = i;
        e.sel   = d[2:0];
        e.ill   = d[3];
        e.imm   = ref_imm(i, d[2:0]);
        return e;
    endfunction

    // behavioural immediate generator sitting next to the controller
    always_comb bus.i_gen_imm = ref_imm(bus.o_gen_instr, bus.o_gen_sel);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mcnt = '0;
        end else begin
            bit mi, mo;
            mi = bus.i_in_valid && (q.size() < 2);
            mo = bus.i_out_ready && (q.size() > 0);
            if (mo) mcnt = mcnt + 16'd1;
            if (bus.i_flush) begin
                q.delete();
            end else begin
                if (mo) void'(q.pop_front());
                if (mi) q.push_back(mk(bus.i_instr));
            end
        end
    end

    always @(negedge clk) begin
        chk("m_out_valid", 32'(bus.o_out_valid), 32'(q.size() > 0));
        chk("m_in_ready", 32'(bus.o_in_ready), 32'(q.size() < 2));
        chk("m_count", 32'(bus.o_dec_count), 32'(mcnt));
        if (q.size() > 0) begin
            chk("m_instr", bus.o_instr, q[0].instr);
            chk("m_imm", bus.o_imm, q[0].imm);
            chk("m_sel", 32'(bus.o_imm_sel), 32'(q[0].sel));
            chk("m_illegal", 32'(bus.o_illegal), 32'(q[0].ill));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] sw_in  [8] = '{32'hFFF00093, 32'h00509093, 32'hFE112E23,
                                32'h00208463, 32'h123452B7, 32'h0000006F,
                                32'h002081B3, 32'h0000007F};
    logic [31:0] sw_imm [8] = '{32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFC,
                                32'h00000008, 32'h12345000, 32'h00000000,
                                32'h00000000, 32'h00000000};
    logic [2:0]  sw_sel [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd7};
    logic        sw_ill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        bus.i_in_valid   = 1'b0;
        bus.i_instr      = '0;
        bus.i_flush      = 1'b0;
        bus.i_out_ready  = 1'b0;
        bus4.i_in_valid  = 1'b0;
        bus4.i_instr     = '0;
        bus4.i_flush     = 1'b0;
        bus4.i_out_ready = 1'b0;
        bus4.i_gen_imm   = '0;

        #12;
        chk("rst_in_ready", 32'(bus.o_in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
        chk("rst_instr", bus.o_instr, 32'd0);
        chk("rst_imm", bus.o_imm, 32'd0);
        chk("rst_sel", 32'(bus.o_imm_sel), 32'd0);
        chk("rst_illegal", 32'(bus.o_illegal), 32'd0);
        chk("rst_count", 32'(bus.o_dec_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // decode sweep, streaming with execute ready
        bus.i_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.i_in_valid = 1'b1;
            bus.i_instr    = sw_in[k];
            #1 chk("gen_sel", 32'(bus.o_gen_sel), 32'(sw_sel[k]));
            chk("gen_instr", bus.o_gen_instr, sw_in[k]);
            @(negedge clk);
            chk("sw_instr", bus.o_instr, sw_in[k]);
            chk("sw_sel", 32'(bus.o_imm_sel), 32'(sw_sel[k]));
            chk("sw_imm", bus.o_imm, sw_imm[k]);
            chk("sw_illegal", 32'(bus.o_illegal), 32'(sw_ill[k]));
        end
        bus.i_in_valid = 1'b0;
        @(negedge clk);
        chk("sw_count", 32'(bus.o_dec_count), 32'd8);

        // backpressure: A, B accepted, C held by fetch
        do_reset();
        bus.i_out_ready = 1'b0;
        bus.i_in_valid  = 1'b1;
        bus.i_instr     = 32'h00A00093;
        @(negedge clk);
        chk("bp_ready_one", 32'(bus.o_in_ready), 32'd1);
        bus.i_instr = 32'h00B00093;
        @(negedge clk);
        chk("bp_ready_two", 32'(bus.o_in_ready), 32'd0);
        chk("bp_head_a", bus.o_instr, 32'h00A00093);
        bus.i_instr = 32'h00C00093;
        @(negedge clk);
        chk("bp_hold_a", bus.o_instr, 32'h00A00093);
        chk("bp_hold_imm", bus.o_imm, 32'h0000000A);
        bus.i_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_b", bus.o_instr, 32'h00B00093);
        chk("bp_ready_back", 32'(bus.o_in_ready), 32'd1);
        @(negedge clk);
        chk("bp_head_c", bus.o_instr, 32'h00C00093);
        bus.i_in_valid = 1'b0;
        @(negedge clk);
        chk("bp_empty", 32'(bus.o_out_valid), 32'd0);
        chk("bp_count", 32'(bus.o_dec_count), 32'd3);

        // streaming 8
        for (int k = 0; k < 8; k++) begin
            bus.i_in_valid = 1'b1;
            bus.i_instr    = 32'h00000093 | (32'(k + 1) << 20);
            @(negedge clk);
            chk("st_ready", 32'(bus.o_in_ready), 32'd1);
            chk("st_instr", bus.o_instr, 32'h00000093 | (32'(k + 1) << 20));
            chk("st_imm", bus.o_imm, 32'(k + 1));
        end
        bus.i_in_valid = 1'b0;
        @(negedge clk);
        chk("st_count", 32'(bus.o_dec_count), 32'd11);

        // flush in TWO, execute stalled
        do_reset();
        bus.i_out_ready = 1'b0;
        bus.i_in_valid  = 1'b1;
        bus.i_instr     = 32'h00100093;
        @(negedge clk);
        bus.i_instr = 32'h00200093;
        @(negedge clk);
        bus.i_instr = 32'h00300093;
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush    = 1'b0;
        bus.i_in_valid = 1'b0;
        chk("fl_valid", 32'(bus.o_out_valid), 32'd0);
        chk("fl_ready", 32'(bus.o_in_ready), 32'd1);
        chk("fl_count", 32'(bus.o_dec_count), 32'd0);

        // flush in TWO with a completing handshake
        bus.i_in_valid = 1'b1;
        bus.i_instr    = 32'h00100093;
        @(negedge clk);
        bus.i_instr = 32'h00200093;
        @(negedge clk);
        bus.i_instr     = 32'h00300093;
        bus.i_flush     = 1'b1;
        bus.i_out_ready = 1'b1;
        @(negedge clk);
        bus.i_flush     = 1'b0;
        bus.i_in_valid  = 1'b0;
        bus.i_out_ready = 1'b0;
        chk("fl2_valid", 32'(bus.o_out_valid), 32'd0);
        chk("fl2_count", 32'(bus.o_dec_count), 32'd1);

        // flush in ONE discards a same-cycle accept
        bus.i_in_valid = 1'b1;
        bus.i_instr    = 32'h00400093;
        @(negedge clk);
        bus.i_instr = 32'h00500093;
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush    = 1'b0;
        bus.i_in_valid = 1'b0;
        chk("fl3_valid", 32'(bus.o_out_valid), 32'd0);
        chk("fl3_count", 32'(bus.o_dec_count), 32'd1);

        // asynchronous reset while in TWO
        bus.i_in_valid = 1'b1;
        bus.i_instr    = 32'h00600093;
        @(negedge clk);
        bus.i_instr = 32'h00700093;
        @(negedge clk);
        bus.i_in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.o_out_valid), 32'd0);
        chk("ar_ready", 32'(bus.o_in_ready), 32'd1);
        chk("ar_instr", bus.o_instr, 32'd0);
        chk("ar_count", 32'(bus.o_dec_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_in_valid  = 1'b1;
        bus.i_out_ready = 1'b1;
        bus.i_instr     = 32'h00509093;
        @(negedge clk);
        bus.i_in_valid = 1'b0;
        chk("ar_first_instr", bus.o_instr, 32'h00509093);
        chk("ar_first_sel", 32'(bus.o_imm_sel), 32'd1);
        chk("ar_first_valid", 32'(bus.o_out_valid), 32'd1);

        // 4-bit counter wraps after 17 handshakes
        bus4.i_in_valid  = 1'b1;
        bus4.i_out_ready = 1'b1;
        bus4.i_instr     = 32'h00000013;
        repeat (18) @(negedge clk);
        bus4.i_in_valid  = 1'b0;
        bus4.i_out_ready = 1'b0;
        chk("cnt4_wrap", 32'(bus4.o_dec_count), 32'd1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_imm_ctrl.md
# decode_imm_ctrl

Decode-stage controller that sits between instruction fetch and execute. It classifies each incoming RISC-V instruction and drives the immediate-select code to the shared combinational immediate generator. It captures the generated immediate and presents instruction, immediate, select code and an illegal flag to execute through a valid/ready handshake. A two-entry skid buffer keeps `o_in_ready` registered.

## Interface
- `CNT_W`, default 16: width of the completed-decode counter.
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_in_valid`  in  1  fetch offers `i_instr`.
- `o_in_ready`  out  1  controller can accept; driven from state register only.
- `i_instr`  in  32  incoming instruction.
- `i_flush`  in  1  discard all held and incoming entries (branch redirect).
- `o_gen_instr`  out  32  to immediate generator `i_instr`; combinationally equal to `i_instr`.
- `o_gen_sel`  out  3  to immediate generator `i_imm_sel`; decoded from `i_instr`.
- `i_gen_imm`  in  32  immediate-generator `o_imm`, same cycle.
- `o_out_valid`  out  1  head entry valid.
- `i_out_ready`  in  1  execute accepts head.
- `o_instr`  out  32  head instruction.
- `o_imm`  out  32  head immediate.
- `o_imm_sel`  out  3  head select code.
- `o_illegal`  out  1  head opcode unsupported.
- `o_dec_count`  out  CNT_W  number of completed output handshakes, wraps modulo 2^CNT_W.

## Operation
- Select decode:
  - If `i_instr[1:0]` is not 2'b11, the instruction is illegal with select 7.
  - Opcode [6:0] 0000011, 1100111 or 1110011 → 0 (I).
  - Opcode 0010011 → 1 (I*) when funct3 [14:12] is 001 or 101, else 0.
  - Opcode 0100011 → 2 (S).
  - Opcode 1100011 → 3 (B).
  - Opcode 0110111 or 0010111 → 4 (U).
  - Opcode 1101111 → 5 (J).
  - Opcode 0110011 → 7 (no immediate, legal).
  - Any other opcode → 7 and illegal.
- Capture: on `in_fire = i_in_valid & o_in_ready`, the entry {`i_instr`, `i_gen_imm`, select, illegal} is written to the main or skid register. The written register is chosen by the state machine.
- State machine, with `out_fire = o_out_valid & i_out_ready`:
  - EMPTY: `in_fire` → ONE (load main).
  - ONE:
    - `in_fire & out_fire` → ONE (main ← new).
    - `in_fire & !out_fire` → TWO (skid ← new).
    - `!in_fire & out_fire` → EMPTY.
    - Neither → ONE (hold).
  - TWO: `out_fire` → ONE (main ← skid); otherwise hold. No `in_fire` is possible in TWO.
- Outputs from state: `o_in_ready` = (state != TWO); `o_out_valid` = (state != EMPTY).
- `o_instr`, `o_imm`, `o_imm_sel` and `o_illegal` always show the main register.
- Ordering: strictly FIFO. The skid entry is never presented before the main entry.
- Flush: when `i_flush` = 1, next state is EMPTY and main/skid are not loaded; an `in_fire` in the same cycle is discarded.
  - An `out_fire` in the flush cycle still counts as completed.
  - Flush overrides every other transition.
- Counter: `o_dec_count` increments by 1 on every `out_fire`, including flush cycles, and wraps from all-ones to 0.
- Illegal entries flow through like any other entry. Their immediate is whatever the generator returns for select 7 (0).

## Timing
- Reset (`i_rst_n` low, asynchronous):
  - State EMPTY.
  - `o_in_ready` = 1, `o_out_valid` = 0.
  - `o_instr`, `o_imm`, `o_dec_count` = 0; `o_imm_sel` = 0; `o_illegal` = 0; skid cleared.
- Reset asserted mid-operation drops all held entries immediately, with no output handshake.
- Latency: an entry accepted at edge N appears on the outputs after edge N when the block was EMPTY, or when it was ONE with a simultaneous `out_fire`.
- Throughput is one instruction per cycle while `i_out_ready` stays high.
- `o_in_ready` falls the cycle after the second unconsumed accept. It rises the cycle after the `out_fire` in TWO.
- `o_gen_instr` / `o_gen_sel` are combinational from `i_instr`. The imm_gen round trip must close in one cycle; `i_gen_imm` is sampled only at the `in_fire` edge.
- Outputs are stable while `o_out_valid & !i_out_ready`.

## Test plan
- Decode sweep, each accepted with `i_out_ready` = 1; every result appears one cycle after accept:
  - 0xFFF00093 → sel 0, imm 0xFFFFFFFF.
  - 0x00509093 → sel 1, imm 0x00000005.
  - 0xFE112E23 → sel 2, imm 0xFFFFFFFC.
  - 0x123452B7 → sel 4, imm 0x12345000.
  - 0x0000006F → sel 5, imm 0.
  - 0x002081B3 → sel 7, imm 0, illegal 0.
  - 0x0000007F → illegal 1, sel 7.
- Backpressure: hold `i_out_ready` = 0 and offer A, B, C back-to-back.
  - A and B are accepted; `o_in_ready` = 0 from the cycle after B's accept; C is held by fetch.
  - Release `i_out_ready` → outputs A, B, C in order; `o_dec_count` = 3.
- Streaming: 8 instructions with `i_in_valid` and `i_out_ready` constantly 1.
  - One output per cycle, `o_in_ready` never drops, state never reaches TWO.
- Flush in TWO while offering a new instruction.
  - Next cycle: `o_out_valid` = 0, `o_in_ready` = 1, the new instruction is dropped, `o_dec_count` is unchanged.
  - Repeat with `i_out_ready` = 1 in the flush cycle → count +1.
- Async reset mid-stream while in TWO.
  - Outputs go to reset values without waiting for an edge; after release, the first accept appears normally.
- `CNT_W` = 4: 17 output handshakes → `o_dec_count` = 1 (wraps through 0).
